// File: rtl/venera_pkg.sv
// ----------------------------------------------------------------------------
// venera_pkg
// Shared constants for the data_memory arbiter slice: default bus widths,
// requester port indices, arbitration mode encodings and the read-return tag.
// No ports (package).
// ----------------------------------------------------------------------------
package venera_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   // Requester indices; also the encoding of last_winner and the tag owner.
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   // Arbitration modes.
   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   // Read-return tag travelling alongside each issued read.
   typedef struct packed {
      logic vld;
      logic owner;
   } tag_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_memory_arbiter_if
// Bundles both requester ports (m0 = CPU data port, m1 = loader/debug) and the
// data_memory side of the arbiter.
//   m0_*/m1_* : write req/addr/data/ack, read req/addr/ack/valid/data
//   data_*    : memory write strobe/addr/data, read strobe/addr, read data
// Modports:
//   master : the environment (requesters plus memory) that drives requests and
//            data_out and observes acks, read returns and memory strobes
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface data_memory_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);

   logic              m0_wr;
   logic [ADDR_W-1:0] m0_wr_address;
   logic [DATA_W-1:0] m0_wr_data;
   logic              m0_wr_ack;
   logic              m0_rd;
   logic [ADDR_W-1:0] m0_rd_address;
   logic              m0_rd_ack;
   logic              m0_rd_valid;
   logic [DATA_W-1:0] m0_rd_data;

   logic              m1_wr;
   logic [ADDR_W-1:0] m1_wr_address;
   logic [DATA_W-1:0] m1_wr_data;
   logic              m1_wr_ack;
   logic              m1_rd;
   logic [ADDR_W-1:0] m1_rd_address;
   logic              m1_rd_ack;
   logic              m1_rd_valid;
   logic [DATA_W-1:0] m1_rd_data;

   logic              data_wr;
   logic [ADDR_W-1:0] data_address_wr;
   logic [DATA_W-1:0] data_in;
   logic              data_rd;
   logic [ADDR_W-1:0] data_address_rd;
   logic [DATA_W-1:0] data_out;

   modport master (
      output m0_wr, m0_wr_address, m0_wr_data, m0_rd, m0_rd_address,
      output m1_wr, m1_wr_address, m1_wr_data, m1_rd, m1_rd_address,
      output data_out,
      input  m0_wr_ack, m0_rd_ack, m0_rd_valid, m0_rd_data,
      input  m1_wr_ack, m1_rd_ack, m1_rd_valid, m1_rd_data,
      input  data_wr, data_address_wr, data_in, data_rd, data_address_rd
   );

   modport slave (
      input  m0_wr, m0_wr_address, m0_wr_data, m0_rd, m0_rd_address,
      input  m1_wr, m1_wr_address, m1_wr_data, m1_rd, m1_rd_address,
      input  data_out,
      output m0_wr_ack, m0_rd_ack, m0_rd_valid, m0_rd_data,
      output m1_wr_ack, m1_rd_ack, m1_rd_valid, m1_rd_data,
      output data_wr, data_address_wr, data_in, data_rd, data_address_rd
   );

endinterface

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way arbiter: round-robin, or fixed priority (port 0 highest) when
// mode_i is set. The grant is combinational from the current requests.
//   clk, areset_n : clock, asynchronous active-low reset
//   req_i[1:0]    : request per port
//   mode_i        : 0 = round-robin, 1 = fixed priority
//   gnt_o[1:0]    : one-hot grant, or zero when nothing is requested
//   winner_o      : index of the granted port (0 when no grant)
// ----------------------------------------------------------------------------
module rr_arbiter2
   import venera_pkg::*;
(
   input  logic       clk,
   input  logic       areset_n,
   input  logic [1:0] req_i,
   input  logic       mode_i,
   output logic [1:0] gnt_o,
   output logic       winner_o
);

   logic last_winner_q;
   logic last_winner_d;

   // Resetting to the AUX port makes the CPU port win the first contention.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         last_winner_q <= PORT_AUX;
      end else begin
         last_winner_q <= last_winner_d;
      end
   end

   always_comb begin
      gnt_o         = 2'b00;
      // Grants are held off while reset is asserted so no ack can leak out.
      if (areset_n) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (mode_i || (last_winner_q == PORT_AUX)) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
      winner_o      = gnt_o[1];
      last_winner_d = (gnt_o != 2'b00) ? winner_o : last_winner_q;
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// ----------------------------------------------------------------------------
// data_memory_arbiter
// Shares one data_memory between the CPU data port (m0) and a loader/debug
// master (m1). Write and read channels are arbitrated independently; granted
// accesses are registered onto the memory strobes one cycle after the ack, and
// a tag pipeline steers each read return to the port that issued it.
//   clk      : system clock
//   areset_n : asynchronous active-low reset
//   bus      : requester ports and data_memory side (slave modport)
// Parameters: ADDR_W, DATA_W, RD_LATENCY (>=1, memory read latency),
//             ARB_MODE (ARB_RR or ARB_FIXED).
// ----------------------------------------------------------------------------
module data_memory_arbiter
   import venera_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LATENCY = 1,
   parameter int ARB_MODE   = ARB_RR
) (
   input  logic                  clk,
   input  logic                  areset_n,
   data_memory_arbiter_if.slave  bus
);

   localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);

   logic [1:0] wr_gnt;
   logic       wr_winner;
   logic [1:0] rd_gnt;
   logic       rd_winner;

   logic              data_wr_q,         data_wr_d;
   logic [ADDR_W-1:0] data_address_wr_q, data_address_wr_d;
   logic [DATA_W-1:0] data_in_q,         data_in_d;
   logic              data_rd_q,         data_rd_d;
   logic [ADDR_W-1:0] data_address_rd_q, data_address_rd_d;

   // Stage 0 lines up with data_rd; stage RD_LATENCY lines up with data_out.
   tag_t [RD_LATENCY:0] tag_q, tag_d;
   tag_t                rd_tag;

   rr_arbiter2 u_wr_arb (
      .clk      (clk),
      .areset_n (areset_n),
      .req_i    ({bus.m1_wr, bus.m0_wr}),
      .mode_i   (FIXED_MODE),
      .gnt_o    (wr_gnt),
      .winner_o (wr_winner)
   );

   rr_arbiter2 u_rd_arb (
      .clk      (clk),
      .areset_n (areset_n),
      .req_i    ({bus.m1_rd, bus.m0_rd}),
      .mode_i   (FIXED_MODE),
      .gnt_o    (rd_gnt),
      .winner_o (rd_winner)
   );

   assign bus.m0_wr_ack = wr_gnt[0];
   assign bus.m1_wr_ack = wr_gnt[1];
   assign bus.m0_rd_ack = rd_gnt[0];
   assign bus.m1_rd_ack = rd_gnt[1];

   always_comb begin
      // Address/data hold their last value on idle cycles.
      data_wr_d         = |wr_gnt;
      data_address_wr_d = data_address_wr_q;
      data_in_d         = data_in_q;
      if (|wr_gnt) begin
         data_address_wr_d = (wr_winner == PORT_AUX) ? bus.m1_wr_address : bus.m0_wr_address;
         data_in_d         = (wr_winner == PORT_AUX) ? bus.m1_wr_data    : bus.m0_wr_data;
      end

      data_rd_d         = |rd_gnt;
      data_address_rd_d = data_address_rd_q;
      if (|rd_gnt) begin
         data_address_rd_d = (rd_winner == PORT_AUX) ? bus.m1_rd_address : bus.m0_rd_address;
      end

      rd_tag.vld   = |rd_gnt;
      rd_tag.owner = rd_winner;
      tag_d        = {tag_q[RD_LATENCY-1:0], rd_tag};
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         data_wr_q         <= 1'b0;
         data_address_wr_q <= '0;
         data_in_q         <= '0;
         data_rd_q         <= 1'b0;
         data_address_rd_q <= '0;
         tag_q             <= '0;
      end else begin
         data_wr_q         <= data_wr_d;
         data_address_wr_q <= data_address_wr_d;
         data_in_q         <= data_in_d;
         data_rd_q         <= data_rd_d;
         data_address_rd_q <= data_address_rd_d;
         tag_q             <= tag_d;
      end
   end

   assign bus.data_wr         = data_wr_q;
   assign bus.data_address_wr = data_address_wr_q;
   assign bus.data_in         = data_in_q;
   assign bus.data_rd         = data_rd_q;
   assign bus.data_address_rd = data_address_rd_q;

   // Read data is a straight pass-through; only the valid is steered.
   assign bus.m0_rd_valid = tag_q[RD_LATENCY].vld && (tag_q[RD_LATENCY].owner == PORT_CPU);
   assign bus.m1_rd_valid = tag_q[RD_LATENCY].vld && (tag_q[RD_LATENCY].owner == PORT_AUX);
   assign bus.m0_rd_data  = bus.data_out;
   assign bus.m1_rd_data  = bus.data_out;

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

   logic clk;
   logic areset_n;
   int   errors;
   int   checks;

   data_memory_arbiter_if #(.ADDR_W(8), .DATA_W(16)) dm_if ();
   data_memory_arbiter_if #(.ADDR_W(8), .DATA_W(16)) fx_if ();

   data_memory_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LATENCY(1), .ARB_MODE(0)) u_dut (
      .clk      (clk),
      .areset_n (areset_n),
      .bus      (dm_if)
   );

   data_memory_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LATENCY(1), .ARB_MODE(1)) u_fix (
      .clk      (clk),
      .areset_n (areset_n),
      .bus      (fx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural data_memory with one cycle of read latency.
   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (dm_if.data_wr) mem[dm_if.data_address_wr] <= dm_if.data_in;
      if (dm_if.data_rd) dm_if.data_out <= mem[dm_if.data_address_rd];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_dm();
      dm_if.m0_wr = 1'b0; dm_if.m0_wr_address = '0; dm_if.m0_wr_data = '0;
      dm_if.m0_rd = 1'b0; dm_if.m0_rd_address = '0;
      dm_if.m1_wr = 1'b0; dm_if.m1_wr_address = '0; dm_if.m1_wr_data = '0;
      dm_if.m1_rd = 1'b0; dm_if.m1_rd_address = '0;
   endtask

   task automatic clear_fx();
      fx_if.m0_wr = 1'b0; fx_if.m0_wr_address = '0; fx_if.m0_wr_data = '0;
      fx_if.m0_rd = 1'b0; fx_if.m0_rd_address = '0;
      fx_if.m1_wr = 1'b0; fx_if.m1_wr_address = '0; fx_if.m1_wr_data = '0;
      fx_if.m1_rd = 1'b0; fx_if.m1_rd_address = '0;
      fx_if.data_out = '0;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      areset_n = 1'b0;
      clear_dm();
      clear_fx();

      // Test 1: reset held with random requests
      for (int i = 0; i < 3; i++) begin
         tick();
         dm_if.m0_wr = 1'($urandom); dm_if.m1_wr = 1'b1;
         dm_if.m0_rd = 1'b1;         dm_if.m1_rd = 1'($urandom);
         dm_if.m0_wr_address = 8'($urandom); dm_if.m0_wr_data = 16'($urandom);
         dm_if.m1_wr_address = 8'($urandom); dm_if.m1_wr_data = 16'($urandom);
         dm_if.m0_rd_address = 8'($urandom); dm_if.m1_rd_address = 8'($urandom);
         @(negedge clk);
         chk("rst_acks", {dm_if.m1_wr_ack, dm_if.m0_wr_ack, dm_if.m1_rd_ack, dm_if.m0_rd_ack}, 4'b0000);
         chk("rst_strobes", {dm_if.data_wr, dm_if.data_rd}, 2'b00);
         chk("rst_valids", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b00);
         chk("rst_addr_wr", dm_if.data_address_wr, 8'h00);
         chk("rst_data_in", dm_if.data_in, 16'h0000);
         chk("rst_addr_rd", dm_if.data_address_rd, 8'h00);
      end

      // Release; contention on writes goes to port 0 first
      tick();
      areset_n = 1'b1;
      clear_dm();
      dm_if.m0_wr = 1'b1; dm_if.m0_wr_address = 8'hF0; dm_if.m0_wr_data = 16'h0000;
      dm_if.m1_wr = 1'b1; dm_if.m1_wr_address = 8'hF1; dm_if.m1_wr_data = 16'h0001;
      @(negedge clk);
      chk("t1_rr_init_ack", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b01);

      // Test 2: lone port 0 write
      tick();
      dm_if.m1_wr = 1'b0;
      dm_if.m0_wr_address = 8'h10; dm_if.m0_wr_data = 16'hABCD;
      @(negedge clk);
      chk("t2_ack", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b01);
      chk("t2_prev_wr", dm_if.data_wr, 1'b1);
      chk("t2_prev_addr", dm_if.data_address_wr, 8'hF0);

      tick();
      dm_if.m0_wr = 1'b0;
      @(negedge clk);
      chk("t2_noack", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b00);
      chk("t2_wr", dm_if.data_wr, 1'b1);
      chk("t2_addr", dm_if.data_address_wr, 8'h10);
      chk("t2_data", dm_if.data_in, 16'hABCD);

      // Idle strobe with held address; lone port 1 write sets last_winner=1
      tick();
      dm_if.m1_wr = 1'b1; dm_if.m1_wr_address = 8'h11; dm_if.m1_wr_data = 16'h5A5A;
      @(negedge clk);
      chk("t2_wr_idle", dm_if.data_wr, 1'b0);
      chk("t2_addr_hold", dm_if.data_address_wr, 8'h10);
      chk("t2_data_hold", dm_if.data_in, 16'hABCD);
      chk("m1_lone_ack", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b10);

      // Test 3: both hold writes
      tick();
      dm_if.m0_wr = 1'b1; dm_if.m0_wr_address = 8'h01; dm_if.m0_wr_data = 16'h1111;
      dm_if.m1_wr = 1'b1; dm_if.m1_wr_address = 8'h02; dm_if.m1_wr_data = 16'h2222;
      @(negedge clk);
      chk("t3_ack_n", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b01);
      chk("m1_wr_addr", dm_if.data_address_wr, 8'h11);
      chk("m1_wr_data", dm_if.data_in, 16'h5A5A);

      tick();
      dm_if.m0_wr = 1'b0;
      @(negedge clk);
      chk("t3_ack_n1", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b10);
      chk("t3_wr_n1", {dm_if.data_wr, dm_if.data_address_wr}, {1'b1, 8'h01});
      chk("t3_data_n1", dm_if.data_in, 16'h1111);

      tick();
      dm_if.m0_wr = 1'b1; dm_if.m0_wr_address = 8'h03; dm_if.m0_wr_data = 16'h3333;
      dm_if.m1_wr = 1'b1; dm_if.m1_wr_address = 8'h04; dm_if.m1_wr_data = 16'h4444;
      @(negedge clk);
      chk("t3_rereq_ack", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b01);
      chk("t3_wr_n2", {dm_if.data_wr, dm_if.data_address_wr}, {1'b1, 8'h02});
      chk("t3_data_n2", dm_if.data_in, 16'h2222);

      tick();
      dm_if.m0_wr = 1'b0;
      @(negedge clk);
      chk("t3_alt_ack", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b10);
      chk("t3_addr_03", dm_if.data_address_wr, 8'h03);

      // Preload mem[0x20]/mem[0x21] through the write channel under contention
      tick();
      dm_if.m0_wr = 1'b1; dm_if.m0_wr_address = 8'h20; dm_if.m0_wr_data = 16'h1234;
      dm_if.m1_wr = 1'b1; dm_if.m1_wr_address = 8'h21; dm_if.m1_wr_data = 16'h5678;
      @(negedge clk);
      chk("pre_ack0", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b01);
      chk("t3_addr_04", {dm_if.data_address_wr, dm_if.data_in}, {8'h04, 16'h4444});

      tick();
      dm_if.m0_wr = 1'b0;
      @(negedge clk);
      chk("pre_ack1", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b10);
      chk("pre_wr0", {dm_if.data_address_wr, dm_if.data_in}, {8'h20, 16'h1234});

      tick();
      dm_if.m1_wr = 1'b0;
      @(negedge clk);
      chk("pre_wr1", {dm_if.data_wr, dm_if.data_address_wr, dm_if.data_in}, {1'b1, 8'h21, 16'h5678});

      // Test 4: m1 reads 0x20 at N, m0 reads 0x21 at N+1
      tick();
      dm_if.m1_rd = 1'b1; dm_if.m1_rd_address = 8'h20;
      @(negedge clk);
      chk("t4_ack_m1", {dm_if.m1_rd_ack, dm_if.m0_rd_ack}, 2'b10);
      chk("t4_wr_idle", dm_if.data_wr, 1'b0);

      tick();
      dm_if.m1_rd = 1'b0;
      dm_if.m0_rd = 1'b1; dm_if.m0_rd_address = 8'h21;
      @(negedge clk);
      chk("t4_ack_m0", {dm_if.m1_rd_ack, dm_if.m0_rd_ack}, 2'b01);
      chk("t4_rd_n1", {dm_if.data_rd, dm_if.data_address_rd}, {1'b1, 8'h20});
      chk("t4_valid_n1", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b00);

      tick();
      dm_if.m0_rd = 1'b0;
      @(negedge clk);
      chk("t4_valid_n2", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b10);
      chk("t4_m1_data", dm_if.m1_rd_data, 16'h1234);
      chk("t4_rd_n2", {dm_if.data_rd, dm_if.data_address_rd}, {1'b1, 8'h21});

      tick();
      @(negedge clk);
      chk("t4_valid_n3", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b01);
      chk("t4_m0_data", dm_if.m0_rd_data, 16'h5678);
      chk("t4_rd_idle", dm_if.data_rd, 1'b0);

      tick();
      @(negedge clk);
      chk("t4_valid_n4", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b00);

      // Test 5: concurrent write (m0) and read (m1)
      tick();
      dm_if.m0_wr = 1'b1; dm_if.m0_wr_address = 8'h30; dm_if.m0_wr_data = 16'hBEEF;
      dm_if.m1_rd = 1'b1; dm_if.m1_rd_address = 8'h40;
      @(negedge clk);
      chk("t5_acks", {dm_if.m0_wr_ack, dm_if.m1_wr_ack, dm_if.m0_rd_ack, dm_if.m1_rd_ack}, 4'b1001);

      tick();
      clear_dm();
      @(negedge clk);
      chk("t5_wr", {dm_if.data_wr, dm_if.data_address_wr, dm_if.data_in}, {1'b1, 8'h30, 16'hBEEF});
      chk("t5_rd", {dm_if.data_rd, dm_if.data_address_rd}, {1'b1, 8'h40});

      tick();
      @(negedge clk);
      chk("t5_valid", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b10);
      chk("t5_idle", {dm_if.data_wr, dm_if.data_rd}, 2'b00);

      // Test 6a: reset while a read is in flight
      tick();
      dm_if.m0_rd = 1'b1; dm_if.m0_rd_address = 8'h10;
      @(negedge clk);
      chk("t6_rd_ack", {dm_if.m1_rd_ack, dm_if.m0_rd_ack}, 2'b01);

      tick();
      dm_if.m0_rd = 1'b0;
      areset_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_rd", dm_if.data_rd, 1'b0);
      chk("t6_rst_valid", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b00);

      // last_winner(wr) was port 0 before reset; reset must restore port 1
      tick();
      areset_n = 1'b1;
      dm_if.m0_wr = 1'b1; dm_if.m0_wr_address = 8'h50;
      dm_if.m1_wr = 1'b1; dm_if.m1_wr_address = 8'h51;
      @(negedge clk);
      chk("t6_valid_drop", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b00);
      chk("t6_rr_reinit", {dm_if.m1_wr_ack, dm_if.m0_wr_ack}, 2'b01);

      tick();
      clear_dm();
      @(negedge clk);
      chk("t6_valid_after", {dm_if.m1_rd_valid, dm_if.m0_rd_valid}, 2'b00);

      // Test 6b: fixed priority, port 1 starves while port 0 reads
      for (int i = 0; i < 5; i++) begin
         tick();
         fx_if.m0_rd = 1'b1; fx_if.m0_rd_address = 8'(i);
         fx_if.m1_rd = 1'b1; fx_if.m1_rd_address = 8'(i + 8'h80);
         @(negedge clk);
         chk("t6_fixed_rd", {fx_if.m1_rd_ack, fx_if.m0_rd_ack}, 2'b01);
      end
      tick();
      fx_if.m0_rd = 1'b0;
      @(negedge clk);
      chk("t6_fixed_m1", {fx_if.m1_rd_ack, fx_if.m0_rd_ack}, 2'b10);

      for (int i = 0; i < 3; i++) begin
         tick();
         fx_if.m1_rd = 1'b0;
         fx_if.m0_wr = 1'b1; fx_if.m1_wr = 1'b1;
         @(negedge clk);
         chk("t6_fixed_wr", {fx_if.m1_wr_ack, fx_if.m0_wr_ack}, 2'b01);
      end
      tick();
      clear_fx();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
